// File: rtl/datapath.sv
// Single-bus 32-bit CPU datapath: register file, priority bus encoder,
// 64-bit result ALU (Y op bus -> Z) and PC update logic.
// Optional feature macro: INPORT_EN (adds in_port_data and the InPort register).
module datapath (
  input  logic        Clock,
  input  logic        Clear,
  input  logic        PCout,
  input  logic        ZHighout,
  input  logic        Zlowout,
  input  logic        HIout,
  input  logic        LOout,
  input  logic        InPortout,
  input  logic        Cout,
  input  logic        MDRout,
  input  logic        R2out,
  input  logic        R4out,
  input  logic        MARin,
  input  logic        PCin,
  input  logic        MDRin,
  input  logic        IRin,
  input  logic        Yin,
  input  logic        IncPC,
  input  logic        Read,
  input  logic [4:0]  ADD,
  input  logic        R5in,
  input  logic        R2in,
  input  logic        R4in,
  input  logic [31:0] Mdatain,
  input  logic        HIin,
  input  logic        LOin,
  input  logic        ZHighIn,
  input  logic        ZLowIn,
  input  logic        Cin,
  input  logic        branch_flag,
  output logic [31:0] bus_mux_out,
  output logic [31:0] mar_q,
  output logic [31:0] ir_q
`ifdef INPORT_EN
  ,
  input  logic [31:0] in_port_data
`endif
);

  typedef enum logic [4:0] {
    OP_ADD  = 5'b00011,
    OP_SUB  = 5'b00100,
    OP_SHR  = 5'b00101,
    OP_SHRA = 5'b00110,
    OP_SHL  = 5'b00111,
    OP_ROR  = 5'b01000,
    OP_ROL  = 5'b01001,
    OP_AND  = 5'b01010,
    OP_OR   = 5'b01011,
    OP_MUL  = 5'b01111,
    OP_DIV  = 5'b10000,
    OP_NEG  = 5'b10001,
    OP_NOT  = 5'b10010
  } alu_op_e;

  logic [31:0] r2_q, r2_d;
  logic [31:0] r4_q, r4_d;
  logic [31:0] r5_q, r5_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_d;
  logic [31:0] mar_d;
  logic [31:0] mdr_q, mdr_d;
  logic [31:0] y_q, y_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] zhigh_q, zhigh_d;
  logic [31:0] zlow_q, zlow_d;
  logic [31:0] in_port_val;
  logic [31:0] c_sext;
  logic [63:0] alu_res;
  logic [63:0] rot;
  logic [31:0] div_b;
  logic        div_zero;
  logic        div_ovf;
  logic [31:0] quo;
  logic [31:0] rem;
  logic [4:0]  shamt;
  alu_op_e     op;
  logic        unused_sink;

`ifdef INPORT_EN
  logic [31:0] in_port_q, in_port_d;

  // InPort samples the external port every cycle
  always_comb begin
    in_port_d = in_port_data;
  end

  assign in_port_val = in_port_q;
`else
  assign in_port_val = '0;
`endif

  // R5 has no bus driver and Cin is reserved; tie them off here
  assign unused_sink = ^{Cin, r5_q};

  assign op     = alu_op_e'(ADD);
  assign c_sext = {{13{ir_q[18]}}, ir_q[18:0]};
  assign shamt  = bus_mux_out[4:0];

  // Fixed-priority bus source select; no strobe leaves the bus at zero
  always_comb begin
    bus_mux_out = '0;
    if (PCout)          bus_mux_out = pc_q;
    else if (ZHighout)  bus_mux_out = zhigh_q;
    else if (Zlowout)   bus_mux_out = zlow_q;
    else if (HIout)     bus_mux_out = hi_q;
    else if (LOout)     bus_mux_out = lo_q;
    else if (InPortout) bus_mux_out = in_port_val;
    else if (Cout)      bus_mux_out = c_sext;
    else if (MDRout)    bus_mux_out = mdr_q;
    else if (R2out)     bus_mux_out = r2_q;
    else if (R4out)     bus_mux_out = r4_q;
  end

  // Divider operands: zero and INT_MIN/-1 divisors are replaced by 1 so the
  // divider never sees them; their results are patched in the ALU mux
  always_comb begin
    div_zero = (bus_mux_out == '0);
    div_ovf  = (y_q == 32'h8000_0000) && (bus_mux_out == '1);
    div_b    = (div_zero || div_ovf) ? 32'd1 : bus_mux_out;
    quo      = $signed(y_q) / $signed(div_b);
    rem      = $signed(y_q) % $signed(div_b);
  end

  // ALU: A = Y, B = bus, 64-bit result; high word zero unless op uses it
  always_comb begin
    alu_res = '0;
    rot     = '0;
    case (op)
      OP_ADD:  alu_res[31:0] = y_q + bus_mux_out;
      OP_SUB:  alu_res[31:0] = y_q - bus_mux_out;
      OP_SHR:  alu_res[31:0] = y_q >> shamt;
      OP_SHRA: alu_res[31:0] = $signed(y_q) >>> shamt;
      OP_SHL:  alu_res[31:0] = y_q << shamt;
      OP_ROR: begin
        rot           = {y_q, y_q} >> shamt;
        alu_res[31:0] = rot[31:0];
      end
      OP_ROL: begin
        rot           = {y_q, y_q} << shamt;
        alu_res[31:0] = rot[63:32];
      end
      OP_AND:  alu_res[31:0] = y_q & bus_mux_out;
      OP_OR:   alu_res[31:0] = y_q | bus_mux_out;
      OP_MUL:  alu_res = $signed({{32{y_q[31]}}, y_q}) *
                         $signed({{32{bus_mux_out[31]}}, bus_mux_out});
      OP_DIV: begin
        if (div_zero)     alu_res = {y_q, 32'hFFFF_FFFF};
        else if (div_ovf) alu_res = {32'h0, 32'h8000_0000};
        else              alu_res = {rem, quo};
      end
      OP_NEG:  alu_res[31:0] = 32'd0 - bus_mux_out;
      OP_NOT:  alu_res[31:0] = ~bus_mux_out;
      default: alu_res = '0;
    endcase
  end

  // Register next-state: each holds unless its enable loads bus or ALU data
  always_comb begin
    r2_d    = r2_q;
    r4_d    = r4_q;
    r5_d    = r5_q;
    y_d     = y_q;
    mar_d   = mar_q;
    ir_d    = ir_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    mdr_d   = mdr_q;
    zlow_d  = zlow_q;
    zhigh_d = zhigh_q;
    if (R2in)    r2_d    = bus_mux_out;
    if (R4in)    r4_d    = bus_mux_out;
    if (R5in)    r5_d    = bus_mux_out;
    if (Yin)     y_d     = bus_mux_out;
    if (MARin)   mar_d   = bus_mux_out;
    if (IRin)    ir_d    = bus_mux_out;
    if (HIin)    hi_d    = bus_mux_out;
    if (LOin)    lo_d    = bus_mux_out;
    if (MDRin)   mdr_d   = Read ? Mdatain : bus_mux_out;
    if (ZLowIn)  zlow_d  = alu_res[31:0];
    if (ZHighIn) zhigh_d = alu_res[63:32];
  end

  // PC next-state: increment beats load; branch_flag makes the load relative
  always_comb begin
    pc_d = pc_q;
    if (IncPC)            pc_d = pc_q + 32'd1;
    else if (PCin) begin
      if (branch_flag)    pc_d = pc_q + bus_mux_out;
      else                pc_d = bus_mux_out;
    end
  end

  // State registers with synchronous active-low clear overriding all enables
  always_ff @(posedge Clock) begin
    if (!Clear) begin
      r2_q      <= '0;
      r4_q      <= '0;
      r5_q      <= '0;
      pc_q      <= '0;
      ir_q      <= '0;
      mar_q     <= '0;
      mdr_q     <= '0;
      y_q       <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      zhigh_q   <= '0;
      zlow_q    <= '0;
`ifdef INPORT_EN
      in_port_q <= '0;
`endif
    end else begin
      r2_q      <= r2_d;
      r4_q      <= r4_d;
      r5_q      <= r5_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      mar_q     <= mar_d;
      mdr_q     <= mdr_d;
      y_q       <= y_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      zhigh_q   <= zhigh_d;
      zlow_q    <= zlow_d;
`ifdef INPORT_EN
      in_port_q <= in_port_d;
`endif
    end
  end

endmodule

// File: tb/tb_datapath.sv
// Directed plus random stimulus for datapath against a behavioural register
// model; internal registers are observed by driving them onto the bus.
module tb_datapath;

  logic        Clock = 1'b0;
  logic        Clear;
  logic        PCout, ZHighout, Zlowout, HIout, LOout, InPortout, Cout;
  logic        MDRout, R2out, R4out;
  logic        MARin, PCin, MDRin, IRin, Yin, IncPC, Read;
  logic [4:0]  ADD;
  logic        R5in, R2in, R4in;
  logic [31:0] Mdatain;
  logic        HIin, LOin, ZHighIn, ZLowIn, Cin, branch_flag;
  logic [31:0] bus_mux_out, mar_q, ir_q;

  int vectors = 0;
  int miscompares = 0;

  // model state
  logic [31:0] mr2, mr4, mr5, mpc, mir, mmar, mmdr, my, mhi, mlo, mzh, mzl;

  // source masks, highest priority in bit 9
  localparam logic [9:0] S_NONE = 10'h000, S_PC = 10'h200, S_ZH = 10'h100,
    S_ZL = 10'h080, S_HI = 10'h040, S_LO = 10'h020, S_IN = 10'h010,
    S_C = 10'h008, S_MDR = 10'h004, S_R2 = 10'h002, S_R4 = 10'h001;
  // load masks
  localparam logic [11:0] L_NONE = 12'h000, L_R2 = 12'h001, L_R4 = 12'h002,
    L_R5 = 12'h004, L_Y = 12'h008, L_MAR = 12'h010, L_IR = 12'h020,
    L_HI = 12'h040, L_LO = 12'h080, L_MDR = 12'h100, L_PC = 12'h200,
    L_ZL = 12'h400, L_ZH = 12'h800;

  datapath dut (
    .Clock(Clock), .Clear(Clear),
    .PCout(PCout), .ZHighout(ZHighout), .Zlowout(Zlowout), .HIout(HIout),
    .LOout(LOout), .InPortout(InPortout), .Cout(Cout), .MDRout(MDRout),
    .R2out(R2out), .R4out(R4out),
    .MARin(MARin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin),
    .IncPC(IncPC), .Read(Read), .ADD(ADD),
    .R5in(R5in), .R2in(R2in), .R4in(R4in), .Mdatain(Mdatain),
    .HIin(HIin), .LOin(LOin), .ZHighIn(ZHighIn), .ZLowIn(ZLowIn),
    .Cin(Cin), .branch_flag(branch_flag),
    .bus_mux_out(bus_mux_out), .mar_q(mar_q), .ir_q(ir_q)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // sign-extended 19-bit immediate from the model IR
  function automatic logic [31:0] c_value();
    int t;
    t = int'(mir << 13);
    return 32'(t >>> 13);
  endfunction

  // first asserted source in priority order wins
  function automatic logic [31:0] exp_bus(input logic [9:0] src);
    logic [31:0] vals [10];
    vals = '{mpc, mzh, mzl, mhi, mlo, 32'h0, c_value(), mmdr, mr2, mr4};
    for (int i = 0; i < 10; i++)
      if (src[9-i]) return vals[i];
    return 32'h0;
  endfunction

  // arithmetic reference ALU
  function automatic logic [63:0] ref_alu(input logic [4:0] op,
                                          input logic [31:0] a, input logic [31:0] b);
    int          ia, ib;
    longint      sa, sb, p, q, r;
    int unsigned sh;
    logic [31:0] x;
    ia = int'(a);
    ib = int'(b);
    sa = longint'(ia);
    sb = longint'(ib);
    sh = int'(b[4:0]);
    x  = a;
    case (op)
      5'd3:  return {32'h0, a + b};
      5'd4:  return {32'h0, a - b};
      5'd5:  return {32'h0, a >> sh};
      5'd6:  begin p = sa >>> sh; return {32'h0, p[31:0]}; end
      5'd7:  return {32'h0, a << sh};
      5'd8:  begin for (int unsigned i = 0; i < sh; i++) x = {x[0], x[31:1]}; return {32'h0, x}; end
      5'd9:  begin for (int unsigned i = 0; i < sh; i++) x = {x[30:0], x[31]}; return {32'h0, x}; end
      5'd10: return {32'h0, a & b};
      5'd11: return {32'h0, a | b};
      5'd15: begin p = sa * sb; return p; end
      5'd16: begin
        if (b == 32'h0) return {a, 32'hFFFF_FFFF};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      5'd17: return {32'h0, 32'h0 - b};
      5'd18: return {32'h0, ~b};
      default: return 64'h0;
    endcase
  endfunction

  // one bus cycle: drive at negedge, check bus, clock, update model, check outputs
  task automatic step(input string tag, input logic [9:0] src, input logic [11:0] ld_in,
                      input logic inc, input logic rd, input logic br,
                      input logic [4:0] op, input logic [31:0] md);
    logic [31:0] eb;
    logic [63:0] ea;
    logic [11:0] ld;
    ld = ld_in;
    @(negedge Clock);
    eb = exp_bus(src);
    // INT_MIN / -1 has no defined result; do not capture it
    if (op == 5'd16 && my == 32'h8000_0000 && eb == 32'hFFFF_FFFF) ld[11:10] = 2'b00;
    Clear = 1'b1;
    {PCout, ZHighout, Zlowout, HIout, LOout, InPortout, Cout, MDRout, R2out, R4out} = src;
    {ZHighIn, ZLowIn, PCin, MDRin, LOin, HIin, IRin, MARin, Yin, R5in, R4in, R2in} = ld;
    IncPC = inc; Read = rd; branch_flag = br; ADD = op; Mdatain = md;
    Cin = 1'($urandom);
    #1;
    chk({tag, ".bus"}, bus_mux_out, eb);
    ea = ref_alu(op, my, eb);
    @(posedge Clock);
    if (ld[0])  mr2  = eb;
    if (ld[1])  mr4  = eb;
    if (ld[2])  mr5  = eb;
    if (ld[3])  my   = eb;
    if (ld[4])  mmar = eb;
    if (ld[5])  mir  = eb;
    if (ld[6])  mhi  = eb;
    if (ld[7])  mlo  = eb;
    if (ld[8])  mmdr = rd ? md : eb;
    if (ld[10]) mzl  = ea[31:0];
    if (ld[11]) mzh  = ea[63:32];
    if (inc)        mpc = mpc + 1;
    else if (ld[9]) mpc = br ? mpc + eb : eb;
    #1;
    chk({tag, ".mar"}, mar_q, mmar);
    chk({tag, ".ir"},  ir_q,  mir);
  endtask

  task automatic do_reset(input string tag);
    @(negedge Clock);
    Clear = 1'b0;
    {PCout, ZHighout, Zlowout, HIout, LOout, InPortout, Cout, MDRout, R2out, R4out} = '1;
    {ZHighIn, ZLowIn, PCin, MDRin, LOin, HIin, IRin, MARin, Yin, R5in, R4in, R2in} = '1;
    IncPC = 1'b1; Read = 1'b1; branch_flag = 1'b1; ADD = 5'd3; Mdatain = 32'hDEAD_BEEF; Cin = 1'b1;
    @(posedge Clock);
    {mr2, mr4, mr5, mpc, mir, mmar, mmdr, my, mhi, mlo, mzh, mzl} = '0;
    #1;
    chk({tag, ".mar"}, mar_q, mmar);
    chk({tag, ".ir"},  ir_q,  mir);
  endtask

  task automatic load_mdr(input logic [31:0] v);
    step("ldmdr", S_NONE, L_MDR, 1'b0, 1'b1, 1'b0, 5'd0, v);
  endtask

  task automatic readback(input string tag);
    step({tag, ".pc"},  S_PC,  L_NONE, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    step({tag, ".zh"},  S_ZH,  L_NONE, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    step({tag, ".zl"},  S_ZL,  L_NONE, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    step({tag, ".hi"},  S_HI,  L_NONE, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    step({tag, ".lo"},  S_LO,  L_NONE, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    step({tag, ".c"},   S_C,   L_NONE, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    step({tag, ".mdr"}, S_MDR, L_NONE, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    step({tag, ".r2"},  S_R2,  L_NONE, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    step({tag, ".r4"},  S_R4,  L_NONE, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
  endtask

  // Y is observable only through the ALU: Y + 0 into ZLow, then read ZLow
  task automatic read_y(input string tag);
    step({tag, ".ycap"}, S_NONE, L_ZL, 1'b0, 1'b0, 1'b0, 5'd3, 32'h0);
    step({tag, ".y"},    S_ZL,   L_NONE, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
  endtask

  task automatic alu_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] op);
    load_mdr(a);
    step({tag, ".y"}, S_MDR, L_Y, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    load_mdr(b);
    step({tag, ".op"}, S_MDR, L_ZL | L_ZH, 1'b0, 1'b0, 1'b0, op, 32'h0);
    step({tag, ".zh"}, S_ZH, L_NONE, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    step({tag, ".zl"}, S_ZL, L_NONE, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
  endtask

  initial begin
    logic [9:0]  rs;
    logic [11:0] rl;
    logic [4:0]  ops [14];
    ops = '{5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10, 5'd11, 5'd15,
            5'd16, 5'd17, 5'd18, 5'd0};
    {mr2, mr4, mr5, mpc, mir, mmar, mmdr, my, mhi, mlo, mzh, mzl} = '0;
    Clear = 1'b0;
    {PCout, ZHighout, Zlowout, HIout, LOout, InPortout, Cout, MDRout, R2out, R4out} = '0;
    {ZHighIn, ZLowIn, PCin, MDRin, LOin, HIin, IRin, MARin, Yin, R5in, R4in, R2in} = '0;
    IncPC = 0; Read = 0; branch_flag = 0; ADD = 0; Mdatain = 0; Cin = 0;

    do_reset("rst0");
    readback("rst0");

    // register load and add sequence
    load_mdr(32'h22);
    step("mdr2r2", S_MDR, L_R2, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    load_mdr(32'h24);
    step("mdr2r4", S_MDR, L_R4, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    step("r2y",    S_R2, L_Y,  1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    step("addz",   S_R4, L_ZL, 1'b0, 1'b0, 1'b0, 5'd3, 32'h0);
    step("zr5",    S_ZL, L_R5, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);

    // fetch
    load_mdr(32'h07);
    step("pcld",  S_MDR, L_PC,  1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    step("fetch", S_PC,  L_MAR, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
    load_mdr(32'h4A92_0000);
    step("irld",  S_MDR, L_IR,  1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    step("pc8",   S_PC,  L_NONE, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    step("cval",  S_C,   L_NONE, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);

    // relative branch: PC=8, bus=4
    load_mdr(32'h4);
    step("branch", S_MDR, L_PC, 1'b0, 1'b0, 1'b1, 5'd0, 32'h0);
    step("pc12",   S_PC,  L_NONE, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    step("incpri", S_MDR, L_PC, 1'b1, 1'b0, 1'b1, 5'd0, 32'h0);
    step("pc13",   S_PC,  L_NONE, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);

    // mul/div including divide by zero (bus = 0 with no strobe)
    alu_op("mul",  32'hFFFF_FFFE, 32'h3, 5'd15);
    alu_op("div",  32'h7, 32'h2, 5'd16);
    alu_op("divn", 32'hFFFF_FFF9, 32'h2, 5'd16);
    load_mdr(32'h7);
    step("y7",   S_MDR,  L_Y, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    step("div0", S_NONE, L_ZL | L_ZH, 1'b0, 1'b0, 1'b0, 5'd16, 32'h0);
    step("div0.zh", S_ZH, L_NONE, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    step("div0.zl", S_ZL, L_NONE, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);

    // shifts and rotates
    alu_op("shra", 32'h8000_0001, 32'h1, 5'd6);
    alu_op("ror",  32'h8000_0001, 32'h1, 5'd8);
    alu_op("rol",  32'h8000_0001, 32'h1, 5'd9);
    alu_op("shl",  32'h8000_0001, 32'h1F, 5'd7);
    alu_op("bad",  32'h1234_5678, 32'h5, 5'd31);

    // priority and empty bus
    step("pri",   S_MDR | S_R2, L_NONE, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    step("pri2",  S_IN | S_R4,  L_NONE, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    step("empty", S_NONE, L_NONE, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);

    // reset with everything enabled
    load_mdr(32'hA5A5_5A5A);
    step("prehi", S_MDR, L_HI | L_LO | L_Y | L_R2 | L_R4, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    do_reset("rst1");
    readback("rst1");
    read_y("rst1");

    // random traffic
    for (int n = 0; n < 400; n++) begin
      rs = 10'($urandom) & 10'($urandom) & 10'($urandom);
      rl = 12'($urandom) & 12'($urandom);
      step("rnd", rs, rl, ($urandom_range(0, 3) == 0), 1'($urandom), 1'($urandom),
           ops[$urandom_range(0, 13)], $urandom);
      if (n % 100 == 99) readback("rndrb");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/datapath.md
Name: datapath

Overview:
- 32-bit single-bus CPU datapath for the phase-1 processor.
- One shared bus driven by a priority encoder from the *out strobes.
- Registers: R2, R4, R5, PC, IR, MAR, MDR, Y, HI, LO, Z (64-bit: ZHigh/ZLow), plus a constant source C.
- The ALU takes Y and the bus, writes Z, and is controlled cycle-by-cycle by an external control unit or testbench.

Parameters:
- none (all widths fixed: data 32, ALU op 5).

Ports:
- Clock  in  1  system clock; all state updates on rising edge.
- Clear  in  1  synchronous, active-low reset.
- PCout, ZHighout, Zlowout, HIout, LOout, InPortout, Cout, MDRout, R2out, R4out  in  1 each  bus source selects.
- MARin, PCin, MDRin, IRin, Yin  in  1 each  register load enables.
- IncPC  in  1  PC increment.
- Read  in  1  MDR source select: 1 = Mdatain, 0 = bus.
- ADD  in  5  ALU operation code.
- R5in, R2in, R4in  in  1 each  GPR load enables.
- Mdatain  in  32  memory read data.
- HIin, LOin, ZHighIn, ZLowIn  in  1 each  load enables.
- Cin  in  1  reserved; no effect.
- branch_flag  in  1  PC load mode.
- bus_mux_out  out  32  current bus value, combinational.
- mar_q  out  32  MAR contents (memory address).
- ir_q  out  32  IR contents.

Behaviour:
- Reset: on a rising edge with Clear=0, every register (R2, R4, R5, PC, IR, MAR, MDR, Y, HI, LO, ZHigh, ZLow, InPort) goes to 0.
  - Reset overrides all enables.
  - A reset mid-operation discards the operation.
- Bus: combinational fixed-priority select. Order: PCout > ZHighout > Zlowout > HIout > LOout > InPortout > Cout > MDRout > R2out > R4out.
  - No strobe asserted → bus = 0.
  - Multiple strobes asserted → highest priority wins; not an error.
- C: sign-extend ir_q[18:0] to 32 bits.
- Register loads, all on the rising edge with Clear=1:
  - Rx <= bus when Rxin. R2in, R4in, R5in, Yin, MARin, IRin, HIin and LOin each load the bus into their register.
  - MDR <= (Read ? Mdatain : bus) when MDRin.
  - ZLow <= alu[31:0] when ZLowIn.
  - ZHigh <= alu[63:32] when ZHighIn.
- Register reads see pre-edge values; a register may drive the bus and load in the same cycle.
- PC:
  - IncPC=1 → PC <= PC+1. IncPC has priority over PCin.
  - Else PCin with branch_flag=0 → PC <= bus.
  - Else PCin with branch_flag=1 → PC <= PC + bus (relative branch).
- ALU: combinational, A = Y, B = bus, 64-bit result. High word = 0 unless stated.
  - 00011 add: A+B, mod 2^32.
  - 00100 sub: A-B, mod 2^32.
  - 00101 shr: logical right shift, amount B[4:0].
  - 00110 shra: arithmetic right shift, amount B[4:0].
  - 00111 shl: left shift, amount B[4:0].
  - 01000 ror: rotate right, amount B[4:0].
  - 01001 rol: rotate left, amount B[4:0].
  - 01010 and: A&B.
  - 01011 or: A|B.
  - 01111 mul: signed A*B; full 64-bit product, high word in [63:32].
  - 10000 div: signed A/B; quotient in [31:0], remainder (sign of A) in [63:32]. B=0 → quotient 0xFFFFFFFF, remainder A.
  - 10001 neg: -B.
  - 10010 not: ~B.
  - Any other code → 0.
- Latency: one bus transfer per cycle. An ALU op takes two cycles: load Y, then load Z.

Optional Feature:
- Macro INPORT_EN.
- Defined: adds input in_port_data[31:0]. The InPort register samples it on every rising edge (reset to 0). InPortout drives InPort onto the bus.
- Undefined: no InPort register and no extra port. InPortout selects constant 0 at its priority position.

Test Plan:
- Register load: Clear=1; Mdatain=0x22, Read=1+MDRin=1 for one edge; then MDRout+R2in for one edge → R2=0x22; bus_mux_out=0x22 during the transfer.
- Add sequence: R2=0x22, R4=0x24; R2out+Yin; then R4out, ADD=00011, ZLowIn; then Zlowout+R5in → R5=0x46.
- Fetch: MDRout=0x07 with PCin → PC=7. Next cycle PCout+MARin+IncPC → mar_q=7, PC=8. Then Mdatain=0x4A920000 via Read/MDRin, MDRout+IRin → ir_q=0x4A920000.
- Mul/div: Y=0xFFFFFFFE (-2), bus=3, op 01111 → ZHigh=0xFFFFFFFF, ZLow=0xFFFFFFFA. Y=7, bus=2, op 10000 → ZLow=3, ZHigh=1. Bus=0 with div → ZLow=0xFFFFFFFF, ZHigh=7.
- Priority/reset: MDRout and R2out asserted together → bus=MDR. No strobes → bus=0. Clear=0 for one edge with all enables high → every register reads 0 afterward.
- Shifts/branch: Y=0x80000001, bus=1 → shra=0xC0000000, ror=0xC0000000, rol=0x00000003. PC=8, bus=4, PCin with branch_flag=1 → PC=12.
